ext_irq_arbiter: RTL and testbench

// - Collects N_SRC platform interrupt sources, gates and prioritises them, and drives the single

---
 rtl/ext_irq_arbiter_if.sv | 26 ++
 rtl/ext_irq_arbiter.sv | 157 +++++++++++++++
 tb/tb_ext_irq_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ext_irq_arbiter_if.sv
// Data-memory bus port into the external-interrupt arbiter register window.
// The CPU side drives the master modport; the arbiter uses the slave modport.
`ifndef ISA__XLEN
`define ISA__XLEN 32
`endif

interface ext_irq_arbiter_if #(
    parameter int XLEN = `ISA__XLEN
) ();
    logic [XLEN-1:0] bus_addr;
    logic [XLEN-1:0] bus_wdata;
    logic            bus_we;
    logic            bus_re;
    logic            bus_sel;
    logic [XLEN-1:0] bus_rdata;

    modport master (
        output bus_addr, bus_wdata, bus_we, bus_re,
        input  bus_sel, bus_rdata
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_we, bus_re,
        output bus_sel, bus_rdata
    );
endinterface

// File: rtl/ext_irq_arbiter.sv
// Gates, prioritises and hands out N_SRC interrupt sources through a claim/complete window.
// Defining EXT_IRQ_ARBITER_EDGE_EN adds the EDGE register and per-source rising-edge requests.
`ifndef ISA__XLEN
`define ISA__XLEN 32
`endif

module ext_irq_arbiter #(
    parameter int                    N_SRC     = 31,
    parameter logic [`ISA__XLEN-1:0] BASE_ADDR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_SRC-1:0]   src_i,
    ext_irq_arbiter_if.slave   bus,
    output logic               exti_o
);
    localparam int XLEN = `ISA__XLEN;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_INSVC = 2'd2
    } src_st_e;

    src_st_e          st_q [N_SRC];
    src_st_e          st_d [N_SRC];
    logic [N_SRC-1:0] en_q, en_d;
    logic [N_SRC-1:0] pend_s, insvc_s, req_s, again_s;
    logic [4:0]       win_idx_s;
    logic             win_valid_s;
    logic [XLEN-1:0]  rdata_q, rdata_d;
    logic             exti_q;
    logic             sel_s, rd_s, wr_s;
    logic [2:0]       reg_s;
    logic             unused_s;

    assign sel_s    = (bus.bus_addr[XLEN-1:5] == BASE_ADDR[XLEN-1:5]);
    assign reg_s    = bus.bus_addr[4:2];
    assign rd_s     = bus.bus_re & sel_s;
    assign wr_s     = bus.bus_we & sel_s;
    assign unused_s = ^{bus.bus_addr[1:0], bus.bus_wdata};

`ifdef EXT_IRQ_ARBITER_EDGE_EN
    logic [N_SRC-1:0] edge_q, edge_d, prev_q, again_q, again_d, rise_s;

    assign rise_s  = edge_q & src_i & ~prev_q;
    assign req_s   = rise_s | (~edge_q & src_i);
    assign again_s = again_q;

    // Remember one extra edge per source while it is already queued or being serviced.
    always_comb begin
        edge_d = (wr_s && (reg_s == 3'd4)) ? bus.bus_wdata[N_SRC-1:0] : edge_q;
        for (int i = 0; i < N_SRC; i++) begin
            again_d[i] = (st_q[i] == ST_IDLE) ? 1'b0 : (again_q[i] | rise_s[i]);
        end
    end

    // Edge configuration, previous-sample and again flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_q  <= '0;
            prev_q  <= '0;
            again_q <= '0;
        end else begin
            edge_q  <= edge_d;
            prev_q  <= src_i;
            again_q <= again_d;
        end
    end
`else
    assign req_s   = src_i;
    assign again_s = '0;
`endif

    // Flatten per-source states into status vectors.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            pend_s[i]  = (st_q[i] == ST_PEND);
            insvc_s[i] = (st_q[i] == ST_INSVC);
        end
    end

    // Lowest enabled pending index wins; scanning downward lets lower indices overwrite.
    always_comb begin
        win_valid_s = 1'b0;
        win_idx_s   = 5'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            win_valid_s = (pend_s[i] && en_q[i]) ? 1'b1   : win_valid_s;
            win_idx_s   = (pend_s[i] && en_q[i]) ? 5'(i) : win_idx_s;
        end
    end

    // Per-source IDLE/PEND/INSVC transitions and ENABLE write.
    always_comb begin
        en_d = (wr_s && (reg_s == 3'd1)) ? bus.bus_wdata[N_SRC-1:0] : en_q;
        for (int i = 0; i < N_SRC; i++) begin
            st_d[i] = st_q[i];
            case (st_q[i])
                ST_IDLE: begin
                    st_d[i] = (req_s[i] || again_s[i]) ? ST_PEND : ST_IDLE;
                end
                ST_PEND: begin
                    st_d[i] = (rd_s && (reg_s == 3'd2) && win_valid_s && (win_idx_s == 5'(i)))
                              ? ST_INSVC : ST_PEND;
                end
                ST_INSVC: begin
                    // IDs 0 and above N_SRC never match any index, so they fall through.
                    st_d[i] = (wr_s && (reg_s == 3'd2) && (bus.bus_wdata[4:0] == 5'(i + 1)))
                              ? ST_IDLE : ST_INSVC;
                end
                default: begin
                    st_d[i] = ST_IDLE;
                end
            endcase
        end
    end

    // Read mux; reads see pre-edge state, so a same-cycle write is not yet visible.
    always_comb begin
        rdata_d = '0;
        if (rd_s) begin
            case (reg_s)
                3'd0:    rdata_d = XLEN'(pend_s);
                3'd1:    rdata_d = XLEN'(en_q);
                3'd2:    rdata_d = win_valid_s ? XLEN'({1'b0, win_idx_s} + 6'd1) : '0;
                3'd3:    rdata_d = XLEN'(insvc_s);
`ifdef EXT_IRQ_ARBITER_EDGE_EN
                3'd4:    rdata_d = XLEN'(edge_q);
`endif
                default: rdata_d = '0;
            endcase
        end else begin
            rdata_d = '0;
        end
    end

    // Source states, ENABLE, read data and interrupt line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= '{default: ST_IDLE};
            en_q    <= '0;
            rdata_q <= '0;
            exti_q  <= 1'b0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                st_q[i] <= st_d[i];
            end
            en_q    <= en_d;
            rdata_q <= rdata_d;
            exti_q  <= |(pend_s & en_q);
        end
    end

    assign bus.bus_sel   = sel_s;
    assign bus.bus_rdata = rdata_q;
    assign exti_o        = exti_q;
endmodule

// File: tb/tb_ext_irq_arbiter.sv
// Directed bench for ext_irq_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_ext_irq_arbiter;
    localparam logic [31:0] P = 32'h00;
    localparam logic [31:0] E = 32'h04;
    localparam logic [31:0] C = 32'h08;
    localparam logic [31:0] I = 32'h0C;
    localparam logic [31:0] G = 32'h10;

    logic        clk;
    logic        rst_n;
    logic [30:0] src;
    logic        exti;
    int          total;
    int          bad;

    ext_irq_arbiter_if bus_if ();

    ext_irq_arbiter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .src_i  (src),
        .bus    (bus_if),
        .exti_o (exti)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [30:0] src;
        logic        ck_rd;
        logic [31:0] rd;
        logic        x;
    } vec_t;

    vec_t tv [35];

    function automatic vec_t mk(input logic we, input logic re, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [30:0] s,
                                input logic ck_rd, input logic [31:0] rd, input logic x);
        vec_t v;
        v.we = we; v.re = re; v.addr = addr; v.wdata = wdata; v.src = s;
        v.ck_rd = ck_rd; v.rd = rd; v.x = x;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock: drive at negedge, sample 1 ns after the rising edge.
    task automatic cyc(input logic we, input logic re, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [30:0] s);
        @(negedge clk);
        bus_if.bus_we    = we;
        bus_if.bus_re    = re;
        bus_if.bus_addr  = addr;
        bus_if.bus_wdata = wdata;
        src              = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        src   = '0;
        bus_if.bus_we    = 1'b0;
        bus_if.bus_re    = 1'b0;
        bus_if.bus_addr  = '0;
        bus_if.bus_wdata = '0;

        tv[0]  = mk(1'b0, 1'b0, P, 32'h0, 31'h0, 1'b1, 32'h0, 1'b0);
        tv[1]  = mk(1'b0, 1'b1, P, 32'h0, 31'h0, 1'b1, 32'h0, 1'b0);
        tv[2]  = mk(1'b1, 1'b0, E, 32'h6, 31'h0, 1'b0, 32'h0, 1'b0);
        tv[3]  = mk(1'b0, 1'b0, P, 32'h0, 31'h6, 1'b0, 32'h0, 1'b0);
        tv[4]  = mk(1'b0, 1'b0, P, 32'h0, 31'h6, 1'b0, 32'h0, 1'b1);
        tv[5]  = mk(1'b0, 1'b1, C, 32'h0, 31'h6, 1'b1, 32'h2, 1'b1);
        tv[6]  = mk(1'b0, 1'b1, C, 32'h0, 31'h6, 1'b1, 32'h3, 1'b1);
        tv[7]  = mk(1'b0, 1'b1, C, 32'h0, 31'h6, 1'b1, 32'h0, 1'b0);
        tv[8]  = mk(1'b0, 1'b1, I, 32'h0, 31'h6, 1'b1, 32'h6, 1'b0);
        tv[9]  = mk(1'b1, 1'b0, C, 32'h2, 31'h6, 1'b0, 32'h0, 1'b0);
        tv[10] = mk(1'b0, 1'b0, P, 32'h0, 31'h6, 1'b0, 32'h0, 1'b0);
        tv[11] = mk(1'b0, 1'b1, P, 32'h0, 31'h6, 1'b1, 32'h2, 1'b1);
        tv[12] = mk(1'b1, 1'b0, C, 32'h5, 31'h6, 1'b0, 32'h0, 1'b1);
        tv[13] = mk(1'b0, 1'b1, I, 32'h0, 31'h6, 1'b1, 32'h4, 1'b1);
        tv[14] = mk(1'b1, 1'b0, C, 32'h0, 31'h6, 1'b0, 32'h0, 1'b1);
        tv[15] = mk(1'b0, 1'b1, I, 32'h0, 31'h6, 1'b1, 32'h4, 1'b1);
        tv[16] = mk(1'b0, 1'b1, C, 32'h0, 31'h0, 1'b1, 32'h2, 1'b1);
        tv[17] = mk(1'b1, 1'b0, C, 32'h2, 31'h0, 1'b0, 32'h0, 1'b0);
        tv[18] = mk(1'b1, 1'b0, C, 32'h3, 31'h0, 1'b0, 32'h0, 1'b0);
        tv[19] = mk(1'b0, 1'b1, I, 32'h0, 31'h0, 1'b1, 32'h0, 1'b0);
        tv[20] = mk(1'b1, 1'b0, E, 32'h0, 31'h1, 1'b0, 32'h0, 1'b0);
        tv[21] = mk(1'b0, 1'b1, P, 32'h0, 31'h1, 1'b1, 32'h1, 1'b0);
        tv[22] = mk(1'b1, 1'b0, E, 32'h1, 31'h1, 1'b0, 32'h0, 1'b0);
        tv[23] = mk(1'b0, 1'b0, P, 32'h0, 31'h0, 1'b0, 32'h0, 1'b1);
        tv[24] = mk(1'b0, 1'b1, E, 32'h0, 31'h0, 1'b1, 32'h1, 1'b1);
        tv[25] = mk(1'b1, 1'b0, E, 32'hFFFF_FFFF, 31'h0, 1'b0, 32'h0, 1'b1);
        tv[26] = mk(1'b0, 1'b1, E, 32'h0, 31'h0, 1'b1, 32'h7FFF_FFFF, 1'b1);
        tv[27] = mk(1'b0, 1'b1, G, 32'h0, 31'h0, 1'b1, 32'h0, 1'b1);
        tv[28] = mk(1'b0, 1'b1, 32'h14, 32'h0, 31'h0, 1'b1, 32'h0, 1'b1);
        tv[29] = mk(1'b1, 1'b1, E, 32'h3, 31'h0, 1'b1, 32'h7FFF_FFFF, 1'b1);
        tv[30] = mk(1'b0, 1'b1, E, 32'h0, 31'h0, 1'b1, 32'h3, 1'b1);
        tv[31] = mk(1'b0, 1'b1, 32'h104, 32'h0, 31'h0, 1'b1, 32'h0, 1'b1);
        tv[32] = mk(1'b0, 1'b1, C, 32'h0, 31'h0, 1'b1, 32'h1, 1'b1);
        tv[33] = mk(1'b1, 1'b0, C, 32'h1, 31'h0, 1'b0, 32'h0, 1'b0);
        tv[34] = mk(1'b0, 1'b1, P, 32'h0, 31'h0, 1'b1, 32'h0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_exti", {31'h0, exti}, 32'h0);
        chk("reset_rdata", bus_if.bus_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 35; k++) begin
            cyc(tv[k].we, tv[k].re, tv[k].addr, tv[k].wdata, tv[k].src);
            if (tv[k].ck_rd) chk($sformatf("vec%0d_rdata", k), bus_if.bus_rdata, tv[k].rd);
            chk($sformatf("vec%0d_exti", k), {31'h0, exti}, {31'h0, tv[k].x});
        end

        // Window decode is combinational on the held address.
        bus_if.bus_addr = 32'h104;
        #1 chk("sel_outside", {31'h0, bus_if.bus_sel}, 32'h0);
        bus_if.bus_addr = 32'h1C;
        #1 chk("sel_inside", {31'h0, bus_if.bus_sel}, 32'h1);

        // Collision: src[3] rises again in the cycle its ID is claimed.
        cyc(1'b1, 1'b0, E, 32'h8, 31'h0);
        cyc(1'b0, 1'b0, P, 32'h0, 31'h8);
        cyc(1'b0, 1'b0, P, 32'h0, 31'h0);
        chk("coll_exti", {31'h0, exti}, 32'h1);
        cyc(1'b0, 1'b1, C, 32'h0, 31'h8);
        chk("coll_claim", bus_if.bus_rdata, 32'h4);
        cyc(1'b0, 1'b1, I, 32'h0, 31'h0);
        chk("coll_insvc", bus_if.bus_rdata, 32'h8);
        cyc(1'b0, 1'b1, P, 32'h0, 31'h0);
        chk("coll_pend", bus_if.bus_rdata, 32'h0);
        cyc(1'b1, 1'b0, C, 32'h4, 31'h0);
        cyc(1'b0, 1'b1, I, 32'h0, 31'h0);
        chk("coll_done", bus_if.bus_rdata, 32'h0);

`ifdef EXT_IRQ_ARBITER_EDGE_EN
        // Edge source: two pulses queue once plus one again flag, the third is dropped.
        cyc(1'b1, 1'b0, E, 32'h1, 31'h0);
        cyc(1'b1, 1'b0, G, 32'h1, 31'h0);
        cyc(1'b0, 1'b1, G, 32'h0, 31'h0);
        chk("edge_reg", bus_if.bus_rdata, 32'h1);
        for (int p = 0; p < 3; p++) begin
            cyc(1'b0, 1'b0, P, 32'h0, 31'h1);
            cyc(1'b0, 1'b0, P, 32'h0, 31'h0);
        end
        for (int r = 0; r < 2; r++) begin
            cyc(1'b0, 1'b1, C, 32'h0, 31'h0);
            chk($sformatf("edge_claim%0d", r), bus_if.bus_rdata, 32'h1);
            cyc(1'b1, 1'b0, C, 32'h1, 31'h0);
            cyc(1'b0, 1'b0, P, 32'h0, 31'h0);
            cyc(1'b0, 1'b1, P, 32'h0, 31'h0);
            chk($sformatf("edge_pend%0d", r), bus_if.bus_rdata, (r == 0) ? 32'h1 : 32'h0);
        end
`endif

        // Reset in the middle of a claim with every source requesting.
        cyc(1'b1, 1'b0, E, 32'hFFFF_FFFF, 31'h7FFF_FFFF);
        cyc(1'b0, 1'b1, E, 32'h0, 31'h7FFF_FFFF);
        chk("prerst_exti", {31'h0, exti}, 32'h1);
        chk("prerst_en", bus_if.bus_rdata, 32'h7FFF_FFFF);
        @(negedge clk);
        bus_if.bus_we   = 1'b0;
        bus_if.bus_re   = 1'b1;
        bus_if.bus_addr = C;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_exti", {31'h0, exti}, 32'h0);
        chk("rst_rdata", bus_if.bus_rdata, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        bus_if.bus_addr = P;
        @(posedge clk);
        #1;
        chk("postrst_pend", bus_if.bus_rdata, 32'h0);
        chk("postrst_exti0", {31'h0, exti}, 32'h0);
        cyc(1'b0, 1'b1, E, 32'h0, 31'h7FFF_FFFF);
        chk("postrst_en", bus_if.bus_rdata, 32'h0);
        chk("postrst_exti1", {31'h0, exti}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
